// File: rtl/dmem_pkg.sv
// Shared types for the data memory unit: size and error encodings, FSM states,
// and the captured request control payload.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_MISAL = 2'b01,
    ERR_RANGE = 2'b10,
    ERR_SIZE  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic  we;
    size_e size;
    logic  is_unsigned;
  } req_ctl_t;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input size_e size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for one memory word.
//   word        : current contents of the addressed word
//   offset      : byte offset of the access within the word
//   size        : log2 of access width in bytes
//   is_unsigned : zero-extend loads when 1, sign-extend when 0
//   wdata       : store data, right-aligned
//   load_data   : extracted and extended load value
//   store_word  : word with the selected lanes replaced by store data
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int unsigned DATA_W = 64,
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word
);

  localparam int unsigned NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] rshift;
  logic [DATA_W-1:0] wshift;
  logic              sign;
  int unsigned       nb;

  // Shift the addressed bytes to lane 0 for loads and to the offset for stores.
  always_comb begin
    rshift     = word >> {offset, 3'b000};
    wshift     = wdata << {offset, 3'b000};
    nb         = 32'(1) << size;
    if (nb > NBYTES) nb = NBYTES;
    sign       = ~is_unsigned & rshift[8*nb-1];
    load_data  = '0;
    store_word = word;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      load_data[8*b +: 8] = (b < nb) ? rshift[8*b +: 8] : {8{sign}};
      if ((b >= 32'(offset)) && (b < 32'(offset) + nb)) begin
        store_word[8*b +: 8] = wshift[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_unit.sv
// Byte-addressed data memory with configurable access latency and a
// single-outstanding valid/ready request/response handshake.
//   req_*  : request channel (valid/ready, we, byte addr, size, unsigned, wdata)
//   resp_* : response channel (valid/ready, rdata, err)
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 48,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(NBYTES);
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] rdata_d;
  logic [1:0]        err_d;
  logic              accept_c;
  logic              access_c;

  req_ctl_t          cap_ctl;
  logic [AW-1:0]     cap_idx;
  logic [OFF_W-1:0]  cap_off;
  logic [DATA_W-1:0] cap_wdata;
  err_e              cap_err;

  logic [IDX_W-1:0]  req_idx;
  err_e              req_err;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;

  // Power-up image of the array is all zeros; words are held XORed with their
  // index so an untouched word i reads back as i, and reset never touches it.
  logic [DATA_W-1:0] mem [DEPTH];

  assign req_idx = req_addr[ADDR_W-1:OFF_W];

  // Request error classification in priority order.
  always_comb begin
    req_err = ERR_OK;
    if ((DATA_W == 32) && (req_size == SZ_D)) begin
      req_err = ERR_SIZE;
    end else if (|(req_addr[2:0] & align_mask(size_e'(req_size)))) begin
      req_err = ERR_MISAL;
    end else if (req_idx >= IDX_W'(DEPTH)) begin
      req_err = ERR_RANGE;
    end
  end

  assign rd_word = mem[cap_idx] ^ DATA_W'(cap_idx);

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .word        (rd_word),
    .offset      (cap_off),
    .size        (cap_ctl.size),
    .is_unsigned (cap_ctl.is_unsigned),
    .wdata       (cap_wdata),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid;
    rdata_d      = resp_rdata;
    err_d        = resp_err;
    accept_c     = 1'b0;
    access_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          cnt_d    = CNT_W'(READ_LAT - 1);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          access_c     = 1'b1;
          resp_valid_d = 1'b1;
          err_d        = cap_err;
          rdata_d      = ((cap_err == ERR_OK) && !cap_ctl.we) ? load_data : '0;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, response and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      cap_ctl    <= '0;
      cap_idx    <= '0;
      cap_off    <= '0;
      cap_wdata  <= '0;
      cap_err    <= ERR_OK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_ready  <= (state_d == IDLE);
      resp_valid <= resp_valid_d;
      resp_rdata <= rdata_d;
      resp_err   <= err_d;
      if (accept_c) begin
        cap_ctl   <= '{we: req_we, size: size_e'(req_size), is_unsigned: req_unsigned};
        cap_idx   <= req_idx[AW-1:0];
        cap_off   <= req_addr[OFF_W-1:0];
        cap_wdata <= req_wdata;
        cap_err   <= req_err;
      end
    end
  end

  // Store commit on the access edge of an error-free store.
  always_ff @(posedge clk) begin
    if (access_c && (cap_err == ERR_OK) && cap_ctl.we) begin
      mem[cap_idx] <= store_word ^ DATA_W'(cap_idx);
    end
  end

endmodule

// File: doc/dmem_unit.md
# dmem_unit

Parametrised, byte-addressed data memory for the RISC-V core's MEM stage, replacing the fixed 64-bit word-indexed data memory. Supports byte/half/word/double loads with sign or zero extension, byte-lane stores, and alignment and range checking. It has a configurable access latency behind a valid/ready request/response handshake, with one request outstanding at a time.

## Interface
- DATA_W, 64: data width in bits; legal values 32 or 64.
- ADDR_W, 48: byte-address width.
- DEPTH, 128: number of DATA_W-bit words.
- READ_LAT, 1: cycles from request acceptance to the array access edge; range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  DATA_W  store data, right-aligned (low bytes used).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  load result; 0 for stores and errors.
- resp_err  out  2  00 = ok, 01 = misaligned, 10 = out of range, 11 = illegal size.

## Operation
- Address split:
  - OFF_W = log2(DATA_W/8).
  - Word index = req_addr[ADDR_W-1:OFF_W]; byte offset = req_addr[OFF_W-1:0].
- Error checks, evaluated at acceptance, in priority order:
  - Illegal size: size 3 when DATA_W = 32.
  - Misaligned: addr is not a multiple of 2^size.
  - Out of range: index >= DEPTH.
- Errored requests never touch the array. They still take the full latency and return rdata = 0.
- Loads: take 2^size bytes starting at the offset, then sign-extend or zero-extend to DATA_W.
- Stores: write only the selected byte lanes from the low bytes of req_wdata. All other bytes of the word stay unchanged.
- FSM states:
  - IDLE: req_ready = 1. On req_valid, capture the request, load cnt = READ_LAT-1, and go to ACCESS.
  - ACCESS: while cnt != 0, decrement cnt. On the cnt == 0 edge, perform the array read or write, register rdata and err, set resp_valid, and go to RESP.
  - RESP: hold resp_valid, resp_rdata and resp_err stable. On resp_ready, clear resp_valid and go to IDLE.
- req_ready is low in ACCESS and RESP. A req_valid asserted in those states is ignored, not queued.
- Array initial contents at time zero: word i = i for every i < DEPTH. Reset does not alter the array.

## Timing
- Request handshake at edge T. Array access and resp_valid rising happen at edge T+READ_LAT.
- Fastest turnaround, with resp_ready held high:
  - resp_valid falls at T+READ_LAT+1, where req_ready is 1 again.
  - Back-to-back requests are therefore accepted every READ_LAT+1 cycles.
- A store is committed at edge T+READ_LAT. A load accepted later always sees that data.
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 00, cnt = 0.
- rst_n asserted mid-operation:
  - Everything returns to IDLE immediately.
  - A store still in ACCESS before its commit edge is dropped, and the array is unchanged.
  - A pending response is discarded.

## Structure
- Package dmem_pkg holds:
  - size encodings: SZ_B, SZ_H, SZ_W, SZ_D.
  - error codes: ERR_OK, ERR_MISAL, ERR_RANGE, ERR_SIZE.
  - FSM state enum: IDLE, ACCESS, RESP.
- Sub-module dmem_lane_align (combinational):
  - Inputs: word, offset, size, unsigned, wdata.
  - Outputs: extended load data, merged store word.
- The top level holds the FSM, latency counter, capture registers and the array.

## Test plan
DATA_W = 64, DEPTH = 128, READ_LAT = 2.
- Load double, addr 0x18 -> resp_valid at T+2, rdata = 0x3, err = 00.
- Store byte 0x80 at 0x21, then load byte 0x21:
  - signed load -> 0xFFFF_FFFF_FFFF_FF80.
  - unsigned load -> 0x80.
  - load double 0x20 -> 0x8004.
- Load half at 0x03 -> err = 01, rdata = 0. Load double 0x0 afterwards -> 0x0, memory unchanged.
- Store double at 0x400 (index 128) -> err = 10, no write. Load double 0x3F8 -> 0x7F.
- resp_ready held low for 5 cycles with req_valid high:
  - resp_valid, rdata and err stay stable and req_ready stays 0.
  - The next request is accepted only after the response handshake.
- rst_n pulsed low one cycle after accepting a store to 0x08 -> resp_valid = 0, req_ready = 1, and load double 0x08 afterwards -> 0x1.
